// File: rtl/btb_pkg.sv
// Shared types and counter arithmetic for the set-associative branch target buffer.
package btb_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam ctr_t CTR_ALLOC = WT;

   function automatic ctr_t ctr_inc(input ctr_t c);
      return (c == ST) ? ST : ctr_t'(c + 2'b01);
   endfunction

   function automatic ctr_t ctr_dec(input ctr_t c);
      return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
   endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and execute-side update signals of the branch target buffer.
interface btb_assoc_if #(
   parameter int PC_W = 16,
   parameter int WAYS = 2
);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [PC_W-1:0]  lk_pc;
   logic             lk_hit;
   logic             lk_taken;
   logic [PC_W-1:0]  lk_target;
   logic             upd_valid;
   logic [PC_W-1:0]  upd_pc;
   logic             upd_taken;
   logic [PC_W-1:0]  upd_target;
   logic             flush;
   logic [WAY_W-1:0] upd_hit_way;

   modport master (
      output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
      input  lk_hit, lk_taken, lk_target, upd_hit_way
   );

   modport slave (
      input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
      output lk_hit, lk_taken, lk_target, upd_hit_way
   );
endinterface

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid/counter/tag/target storage with lookup and update tag compares.
module btb_way
   import btb_pkg::*;
#(
   parameter int PC_W  = 16,
   parameter int IDX_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [IDX_W-1:0]      lk_idx,
   input  logic [PC_W-IDX_W-1:0] lk_tag,
   output logic                  lk_match,
   output logic                  lk_taken,
   output logic [PC_W-1:0]       lk_target,
   input  logic [IDX_W-1:0]      up_idx,
   input  logic [PC_W-IDX_W-1:0] up_tag,
   output logic                  up_match,
   output logic                  up_valid,
   output logic [PC_W-1:0]       up_target,
   output ctr_t                  up_ctr,
   input  logic                  we,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic                  wr_valid,
   input  logic [PC_W-IDX_W-1:0] wr_tag,
   input  logic [PC_W-1:0]       wr_target,
   input  ctr_t                  wr_ctr
);
   localparam int SETS  = 1 << IDX_W;
   localparam int TAG_W = PC_W - IDX_W;

   logic [SETS-1:0]  valid_q;
   ctr_t             ctr_q    [SETS];
   logic [TAG_W-1:0] tag_q    [SETS];
   logic [PC_W-1:0]  target_q [SETS];

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int s = 0; s < SETS; s++) ctr_q[s] <= SNT;
      end else begin
         if (flush)   valid_q         <= '0;
         else if (we) valid_q[wr_idx] <= wr_valid;
         if (we)      ctr_q[wr_idx]   <= wr_ctr;
      end
   end

   // NOTE: tag/target arrays carry no reset; an entry is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
      end
   end

   assign lk_match  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_taken  = ctr_q[lk_idx][1];
   assign lk_target = target_q[lk_idx];

   assign up_valid  = valid_q[up_idx];
   assign up_match  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_target = target_q[up_idx];
   assign up_ctr    = ctr_q[up_idx];
endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB: zero-latency lookup, single update port, per-set round-robin victim choice.
module btb_assoc
   import btb_pkg::*;
#(
   parameter int PC_W = 16,
   parameter int SETS = 256,
   parameter int WAYS = 2
) (
   input logic        clk,
   input logic        rst_n,
   btb_assoc_if.slave bus
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = PC_W - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      ctr_t             ctr;
   } entry_t;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   assign lk_idx = bus.lk_pc[IDX_W-1:0];
   assign lk_tag = bus.lk_pc[PC_W-1:IDX_W];
   assign up_idx = bus.upd_pc[IDX_W-1:0];
   assign up_tag = bus.upd_pc[PC_W-1:IDX_W];

   logic [WAYS-1:0] lk_match, lk_taken_w, up_match, up_valid;
   logic [PC_W-1:0] lk_tgt_w [WAYS];
   logic [PC_W-1:0] up_tgt_w [WAYS];
   ctr_t            up_ctr_w [WAYS];

   logic             we;
   logic [WAY_W-1:0] wr_way;
   entry_t           wr_ent;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      btb_way #(.PC_W(PC_W), .IDX_W(IDX_W)) u_way (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (bus.flush),
         .lk_idx    (lk_idx),
         .lk_tag    (lk_tag),
         .lk_match  (lk_match[w]),
         .lk_taken  (lk_taken_w[w]),
         .lk_target (lk_tgt_w[w]),
         .up_idx    (up_idx),
         .up_tag    (up_tag),
         .up_match  (up_match[w]),
         .up_valid  (up_valid[w]),
         .up_target (up_tgt_w[w]),
         .up_ctr    (up_ctr_w[w]),
         .we        (we && (wr_way == WAY_W'(w))),
         .wr_idx    (up_idx),
         .wr_valid  (wr_ent.valid),
         .wr_tag    (wr_ent.tag),
         .wr_target (wr_ent.target),
         .wr_ctr    (wr_ent.ctr)
      );
   end

   // Descending scan so the lowest matching way is the one left standing.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      bus.lk_hit    = 1'b0;
      bus.lk_taken  = 1'b0;
      bus.lk_target = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (lk_match[w]) begin
            bus.lk_hit    = 1'b1;
            bus.lk_taken  = lk_taken_w[w];
            bus.lk_target = lk_tgt_w[w];
         end
      end
   end

   logic             up_hit, have_free, rr_adv;
   logic [WAY_W-1:0] hit_way, free_way, rr_next;
   logic [PC_W-1:0]  cur_target;
   ctr_t             cur_ctr;
   logic [WAY_W-1:0] rr_q [SETS];
   logic [WAY_W-1:0] hit_way_q;

   always_comb begin
      up_hit     = 1'b0;
      hit_way    = '0;
      cur_target = '0;
      cur_ctr    = SNT;
      have_free  = 1'b0;
      free_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (up_match[w]) begin
            up_hit     = 1'b1;
            hit_way    = WAY_W'(w);
            cur_target = up_tgt_w[w];
            cur_ctr    = up_ctr_w[w];
         end
         if (!up_valid[w]) begin
            have_free = 1'b1;
            free_way  = WAY_W'(w);
         end
      end

      rr_next = (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;

      we            = 1'b0;
      rr_adv        = 1'b0;
      wr_way        = hit_way;
      wr_ent.valid  = 1'b1;
      wr_ent.tag    = up_tag;
      wr_ent.target = bus.upd_target;
      wr_ent.ctr    = CTR_ALLOC;
      if (bus.upd_valid && !bus.flush) begin
         if (up_hit) begin
            we = 1'b1;
            if (!bus.upd_taken) begin
               wr_ent.ctr    = ctr_dec(cur_ctr);
               wr_ent.target = cur_target;
            end else if (cur_target == bus.upd_target) begin
               wr_ent.ctr = ctr_inc(cur_ctr);
            end
         end else if (bus.upd_taken) begin
            we = 1'b1;
            if (have_free) begin
               wr_way = free_way;
            end else begin
               wr_way = rr_q[up_idx];
               rr_adv = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
         hit_way_q <= '0;
      end else if (bus.flush) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else begin
         if (rr_adv) rr_q[up_idx] <= rr_next;
         if (we)     hit_way_q    <= wr_way;
      end
   end

   assign bus.upd_hit_way = hit_way_q;
endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc with PC_W=16, SETS=256, WAYS=2.
module tb_btb_assoc;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   btb_assoc_if #(.PC_W(16), .WAYS(2)) bus ();

   btb_assoc #(.PC_W(16), .SETS(256), .WAYS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [17:0] lk_all;
   assign lk_all = {bus.lk_hit, bus.lk_taken, bus.lk_target};

   task automatic look(input logic [15:0] pc);
      bus.lk_pc = pc;
      #1;
   endtask

   task automatic do_upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_taken  = tk;
      bus.upd_target = tgt;
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_taken  = 1'b0;
      bus.upd_target = '0;
      bus.flush      = 1'b0;
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset_lookup: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
      checks++;
      if (bus.upd_hit_way !== 1'b0) begin
         errors++;
         $display("FAIL reset_hit_way: got %0d expected 0", bus.upd_hit_way);
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_alloc();
      do_upd(16'h1234, 1'b1, 16'h2000);
      checks++;
      if (bus.upd_hit_way !== 1'b0) begin
         errors++;
         $display("FAIL alloc_way: got %0d expected 0", bus.upd_hit_way);
      end
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2000}) begin
         errors++;
         $display("FAIL alloc_hit: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2000});
      end
      look(16'h5634);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL alloc_other_tag: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
   endtask

   task automatic test_counter();
      do_upd(16'h1234, 1'b0, 16'h2000);
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b1, 1'b0, 16'h2000}) begin
         errors++;
         $display("FAIL ctr_wnt: got %h expected %h", lk_all, {1'b1, 1'b0, 16'h2000});
      end
      do_upd(16'h1234, 1'b0, 16'h2000);
      do_upd(16'h1234, 1'b0, 16'h2000);
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b1, 1'b0, 16'h2000}) begin
         errors++;
         $display("FAIL ctr_snt_sat: got %h expected %h", lk_all, {1'b1, 1'b0, 16'h2000});
      end
      do_upd(16'h1234, 1'b1, 16'h2000);
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b1, 1'b0, 16'h2000}) begin
         errors++;
         $display("FAIL ctr_up_wnt: got %h expected %h", lk_all, {1'b1, 1'b0, 16'h2000});
      end
      do_upd(16'h1234, 1'b1, 16'h2000);
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2000}) begin
         errors++;
         $display("FAIL ctr_up_wt: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2000});
      end
      // 10 -> 11 -> 11 -> 10 -> 01; a wrapping counter would read not-taken one step early
      do_upd(16'h1234, 1'b1, 16'h2000);
      do_upd(16'h1234, 1'b1, 16'h2000);
      do_upd(16'h1234, 1'b0, 16'h2000);
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2000}) begin
         errors++;
         $display("FAIL ctr_st_sat: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2000});
      end
      do_upd(16'h1234, 1'b0, 16'h2000);
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b1, 1'b0, 16'h2000}) begin
         errors++;
         $display("FAIL ctr_st_dec: got %h expected %h", lk_all, {1'b1, 1'b0, 16'h2000});
      end
      do_upd(16'h1234, 1'b1, 16'h2000);
   endtask

   task automatic test_replace();
      do_upd(16'h5634, 1'b1, 16'h2100);
      checks++;
      if (bus.upd_hit_way !== 1'b1) begin
         errors++;
         $display("FAIL fill_way1: got %0d expected 1", bus.upd_hit_way);
      end
      do_upd(16'h9A34, 1'b1, 16'h2200);
      checks++;
      if (bus.upd_hit_way !== 1'b0) begin
         errors++;
         $display("FAIL repl_way0: got %0d expected 0", bus.upd_hit_way);
      end
      look(16'h1234);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL repl_evicted: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
      look(16'h5634);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2100}) begin
         errors++;
         $display("FAIL repl_kept: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2100});
      end
      do_upd(16'hBC34, 1'b1, 16'h2300);
      checks++;
      if (bus.upd_hit_way !== 1'b1) begin
         errors++;
         $display("FAIL repl_way1: got %0d expected 1", bus.upd_hit_way);
      end
      look(16'h5634);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL repl2_evicted: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
      look(16'h9A34);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2200}) begin
         errors++;
         $display("FAIL repl2_kept: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2200});
      end
      look(16'hBC34);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2300}) begin
         errors++;
         $display("FAIL repl2_new: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2300});
      end
      do_upd(16'h4411, 1'b0, 16'h5555);
      checks++;
      if (bus.upd_hit_way !== 1'b1) begin
         errors++;
         $display("FAIL nt_miss_hold: got %0d expected 1", bus.upd_hit_way);
      end
      look(16'h4411);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL nt_miss_noalloc: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
   endtask

   task automatic test_retarget();
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 16'h9A34;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 16'h3000;
      look(16'h9A34);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2200}) begin
         errors++;
         $display("FAIL retarget_no_bypass: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2200});
      end
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      look(16'h9A34);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h3000}) begin
         errors++;
         $display("FAIL retarget_new: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h3000});
      end
      checks++;
      if (bus.upd_hit_way !== 1'b0) begin
         errors++;
         $display("FAIL retarget_way: got %0d expected 0", bus.upd_hit_way);
      end
      do_upd(16'h9A34, 1'b0, 16'h3000);
      look(16'h9A34);
      checks++;
      if (lk_all !== {1'b1, 1'b0, 16'h3000}) begin
         errors++;
         $display("FAIL retarget_ctr_wt: got %h expected %h", lk_all, {1'b1, 1'b0, 16'h3000});
      end
   endtask

   task automatic test_flush();
      do_upd(16'hDE34, 1'b1, 16'h2400);
      bus.flush      = 1'b1;
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 16'h7700;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 16'h1111;
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.upd_valid = 1'b0;
      look(16'h7700);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL flush_drop_upd: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
      look(16'hDE34);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL flush_clear: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
      // Pointer was 1 before the flush; a cleared pointer sends the third fill to way 0
      do_upd(16'h1234, 1'b1, 16'h2000);
      do_upd(16'h5634, 1'b1, 16'h2100);
      do_upd(16'h9A34, 1'b1, 16'h2200);
      checks++;
      if (bus.upd_hit_way !== 1'b0) begin
         errors++;
         $display("FAIL flush_rr_clear: got %0d expected 0", bus.upd_hit_way);
      end
      look(16'h5634);
      checks++;
      if (lk_all !== {1'b1, 1'b1, 16'h2100}) begin
         errors++;
         $display("FAIL flush_refill: got %h expected %h", lk_all, {1'b1, 1'b1, 16'h2100});
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      look(16'h5634);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
      checks++;
      if (bus.upd_hit_way !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_way: got %0d expected 0", bus.upd_hit_way);
      end
      do_upd(16'h7700, 1'b1, 16'h1111);
      #2 rst_n = 1'b1;
      look(16'h7700);
      checks++;
      if (lk_all !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset_drop_upd: got %h expected %h", lk_all, {1'b0, 1'b0, 16'h0000});
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_alloc();
      test_counter();
      test_replace();
      test_retarget();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
